// File: rtl/scene_render.sv
// Sprite compositor: two player rectangles, a shuttle square and a fixed net drawn over the timing-generator raster.
// Latency: 2 cycles from hdata/vdata to rgb/de. pos_ready drops only in reset and in the commit cycle.
module scene_render #(
  parameter int WIDTH = 12,
  parameter int HSIZE = 800,
  parameter int VSIZE = 600,
  parameter bit HSPP  = 1'b1,
  parameter bit VSPP  = 1'b1,
  parameter int PW    = 32,
  parameter int PH    = 64,
  parameter int SS    = 8,
  parameter int NET_X = 396
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] hdata,
  input  logic [WIDTH-1:0] vdata,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             pos_valid,
  output logic             pos_ready,
  input  logic [1:0]       pos_id,
  input  logic [WIDTH-1:0] pos_x,
  input  logic [WIDTH-1:0] pos_y,
  output logic             frame_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue
);

  localparam int NET_W = 8;
  localparam int NET_Y = 400;

  // Index 0 = player0, 1 = player1, 2 = shuttle.
  localparam logic [2:0][WIDTH-1:0] RST_X = {WIDTH'(396), WIDTH'(668), WIDTH'(100)};
  localparam logic [2:0][WIDTH-1:0] RST_Y = {WIDTH'(200), WIDTH'(472), WIDTH'(472)};
  localparam logic [2:0][WIDTH:0]   OBJ_W = {(WIDTH+1)'(SS), (WIDTH+1)'(PW), (WIDTH+1)'(PW)};
  localparam logic [2:0][WIDTH:0]   OBJ_H = {(WIDTH+1)'(SS), (WIDTH+1)'(PH), (WIDTH+1)'(PH)};

  logic [2:0][WIDTH-1:0] pend_x, pend_y, act_x, act_y;
  logic                  commit;
  logic                  accept;

  assign commit    = (hdata == '0) && (vdata == WIDTH'(VSIZE));
  assign pos_ready = !rst_n && !commit;
  assign accept    = pos_valid && pos_ready;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pend_x     <= RST_X;
      pend_y     <= RST_Y;
      act_x      <= RST_X;
      act_y      <= RST_Y;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= commit;
      if (commit) begin
        act_x <= pend_x;
        act_y <= pend_y;
      end
      // Reserved id 3 is accepted but writes nothing.
      if (accept && pos_id != 2'd3) begin
        pend_x[pos_id] <= pos_x;
        pend_y[pos_id] <= pos_y;
      end
    end
  end

  // Stage 1: hit tests in WIDTH+1 bits so x+w never wraps back onto column 0.
  logic [WIDTH:0] h_ext, v_ext;
  logic [2:0]     hit_nxt;
  logic           net_nxt, vis_nxt;

  assign h_ext = {1'b0, hdata};
  assign v_ext = {1'b0, vdata};

  always_comb begin
    hit_nxt = '0;
    for (int i = 0; i < 3; i++) begin
      hit_nxt[i] = (h_ext >= {1'b0, act_x[i]}) && (h_ext < {1'b0, act_x[i]} + OBJ_W[i]) &&
                   (v_ext >= {1'b0, act_y[i]}) && (v_ext < {1'b0, act_y[i]} + OBJ_H[i]);
    end
  end

  assign net_nxt = (h_ext >= (WIDTH+1)'(NET_X)) && (h_ext < (WIDTH+1)'(NET_X + NET_W)) &&
                   (v_ext >= (WIDTH+1)'(NET_Y)) && (v_ext < (WIDTH+1)'(VSIZE));
  assign vis_nxt = (h_ext < (WIDTH+1)'(HSIZE)) && (v_ext < (WIDTH+1)'(VSIZE));

  logic [2:0] s1_hit;
  logic       s1_net, s1_vis, s1_hs, s1_vs;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_hit <= '0;
      s1_net <= 1'b0;
      s1_vis <= 1'b0;
      s1_hs  <= !HSPP;
      s1_vs  <= !VSPP;
    end else begin
      s1_hit <= hit_nxt;
      s1_net <= net_nxt;
      s1_vis <= vis_nxt;
      s1_hs  <= hsync_in;
      s1_vs  <= vsync_in;
    end
  end

  // Stage 2: priority colour select.
  logic [23:0] rgb_nxt;

  always_comb begin
    rgb_nxt = 24'h00A000;
    if (!s1_vis)        rgb_nxt = 24'h000000;
    else if (s1_hit[2]) rgb_nxt = 24'hFFFFFF;
    else if (s1_hit[0]) rgb_nxt = 24'hFF0000;
    else if (s1_hit[1]) rgb_nxt = 24'h0000FF;
    else if (s1_net)    rgb_nxt = 24'hC0C0C0;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      {red, green, blue} <= '0;
      de                 <= 1'b0;
      hsync              <= !HSPP;
      vsync              <= !VSPP;
    end else begin
      {red, green, blue} <= rgb_nxt;
      de                 <= s1_vis;
      hsync              <= s1_hs;
      vsync              <= s1_vs;
    end
  end

endmodule

// File: tb/tb_scene_render.sv
// Directed bench for scene_render: pixel colours, position commit, sync delay and reset behaviour.
module tb_scene_render;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] hdata, vdata;
  logic        hsync_in, vsync_in;
  logic        pos_valid, pos_ready;
  logic [1:0]  pos_id;
  logic [11:0] pos_x, pos_y;
  logic        frame_tick, hsync, vsync, de;
  logic [7:0]  red, green, blue;

  int n_cmp = 0;
  int n_bad = 0;

  scene_render dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hdata     (hdata),
    .vdata     (vdata),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready),
    .pos_id    (pos_id),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .frame_tick(frame_tick),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [23:0] rgb, input logic de_exp);
    hdata = 12'(h);
    vdata = 12'(v);
    step();
    step();
    chk({tag, " rgb"}, {8'h0, red, green, blue}, {8'h0, rgb});
    chk({tag, " de"}, {31'h0, de}, {31'h0, de_exp});
  endtask

  task automatic wr(input logic [1:0] id, input int x, input int y);
    hdata     = 12'd5;
    vdata     = 12'd10;
    pos_valid = 1'b1;
    pos_id    = id;
    pos_x     = 12'(x);
    pos_y     = 12'(y);
    #1;
    chk("wr ready", {31'h0, pos_ready}, 32'd1);
    step();
    pos_valid = 1'b0;
  endtask

  task automatic commit_frame();
    hdata = 12'd0;
    vdata = 12'd600;
    #1;
    chk("commit ready", {31'h0, pos_ready}, 32'd0);
    step();
    chk("tick high", {31'h0, frame_tick}, 32'd1);
    hdata = 12'd1;
    step();
    chk("tick low", {31'h0, frame_tick}, 32'd0);
  endtask

  logic [5:0] hpat, vpat;
  logic       hprev, vprev;

  initial begin
    rst_n     = 1'b1;
    hdata     = 12'd5;
    vdata     = 12'd10;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    pos_valid = 1'b0;
    pos_id    = 2'd0;
    pos_x     = 12'd0;
    pos_y     = 12'd0;

    // Reset state, with sync inputs asserted to prove the outputs are forced inactive.
    step(); step(); step();
    chk("rst rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst de", {31'h0, de}, 32'd0);
    chk("rst tick", {31'h0, frame_tick}, 32'd0);
    chk("rst ready", {31'h0, pos_ready}, 32'd0);
    chk("rst hsync", {31'h0, hsync}, 32'd0);
    chk("rst vsync", {31'h0, vsync}, 32'd0);

    hsync_in = 1'b0;
    vsync_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("release ready", {31'h0, pos_ready}, 32'd1);

    pix("p0 reset pos", 110, 500, 24'hFF0000, 1'b1);

    // Pending shuttle write must not show until commit.
    wr(2'd2, 0, 0);
    pix("shuttle pending", 0, 0, 24'h00A000, 1'b1);
    commit_frame();
    pix("shuttle active", 0, 0, 24'hFFFFFF, 1'b1);

    // Update held across the commit cycle is taken on the following cycle.
    hdata     = 12'd0;
    vdata     = 12'd600;
    pos_valid = 1'b1;
    pos_id    = 2'd0;
    pos_x     = 12'd200;
    pos_y     = 12'd100;
    #1;
    chk("held ready commit", {31'h0, pos_ready}, 32'd0);
    step();
    hdata = 12'd1;
    #1;
    chk("held ready after", {31'h0, pos_ready}, 32'd1);
    step();
    pos_valid = 1'b0;
    pix("held pending", 210, 110, 24'h00A000, 1'b1);
    commit_frame();
    pix("held active", 210, 110, 24'hFF0000, 1'b1);
    pix("p0 old spot", 110, 500, 24'h00A000, 1'b1);

    // Right-edge shuttle and near-max player0: no wrap onto low columns.
    wr(2'd2, 796, 0);
    wr(2'd0, 4090, 0);
    commit_frame();
    pix("edge 796", 796, 0, 24'hFFFFFF, 1'b1);
    pix("edge 799", 799, 0, 24'hFFFFFF, 1'b1);
    pix("edge 795", 795, 0, 24'h00A000, 1'b1);
    pix("nowrap col0", 0, 0, 24'h00A000, 1'b1);
    pix("nowrap col20", 20, 0, 24'h00A000, 1'b1);
    pix("edge 800", 800, 0, 24'h000000, 1'b0);

    // Priority and overlap.
    wr(2'd0, 100, 472);
    wr(2'd2, 110, 480);
    wr(2'd1, 120, 490);
    wr(2'd3, 0, 0);
    commit_frame();
    pix("shuttle over p0", 112, 482, 24'hFFFFFF, 1'b1);
    pix("p0 only", 105, 475, 24'hFF0000, 1'b1);
    pix("p0 over p1", 125, 495, 24'hFF0000, 1'b1);
    pix("p1 only", 140, 495, 24'h0000FF, 1'b1);
    pix("net", 398, 450, 24'hC0C0C0, 1'b1);
    pix("net above", 398, 399, 24'h00A000, 1'b1);
    pix("hblank", 800, 480, 24'h000000, 1'b0);
    pix("vblank", 10, 600, 24'h000000, 1'b0);
    pix("id3 ignored", 2, 2, 24'h00A000, 1'b1);

    // Sync outputs trail inputs by two cycles.
    hpat  = 6'b101011;
    vpat  = 6'b010110;
    hprev = 1'b0;
    vprev = 1'b0;
    hdata = 12'd5;
    vdata = 12'd10;
    for (int i = 0; i < 6; i++) begin
      hsync_in = hpat[i];
      vsync_in = vpat[i];
      step();
      chk("hsync delay", {31'h0, hsync}, {31'h0, hprev});
      chk("vsync delay", {31'h0, vsync}, {31'h0, vprev});
      hprev = hpat[i];
      vprev = vpat[i];
    end

    // Pending write followed by reset is discarded.
    wr(2'd2, 300, 300);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rst_n    = 1'b1;
    step();
    chk("mid rst hsync", {31'h0, hsync}, 32'd0);
    chk("mid rst vsync", {31'h0, vsync}, 32'd0);
    chk("mid rst de", {31'h0, de}, 32'd0);
    step();
    chk("mid rst rgb", {8'h0, red, green, blue}, 32'h0);
    rst_n    = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    #1;
    chk("mid release ready", {31'h0, pos_ready}, 32'd1);
    commit_frame();
    pix("discarded pend", 302, 302, 24'h00A000, 1'b1);
    pix("shuttle reset pos", 398, 202, 24'hFFFFFF, 1'b1);
    pix("p0 reset again", 105, 475, 24'hFF0000, 1'b1);
    pix("p1 reset pos", 670, 480, 24'h0000FF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
